can_bit_timing_rx: RTL and testbench
====================================

// Module: can_bit_timing_rx
// PURPOSE
//  Receive-side bit-timing recovery for the CAN controller; the counterpart to the transmit bit-rate divider.
//  Synchronises the asynchronous canRx line and splits each bit into SYNC/TSEG1/TSEG2 time quanta (tq).
//  Hard-syncs on the first dominant edge after bus idle; resyncs (SJW-limited) on later edges.
//  Emits a 1-clock sample strobe with the sampled bit, plus a bit-start strobe for the transmitter.
// PARAMETERS
//  BRP_W   8   width of brp (tq prescaler)
//  SEG_W   4   width of tseg1/tseg2/sjw
//  IDLE_N  11  consecutive recessive samples that declare bus idle
// PORTS
//  clk50Mhz     in   1      system clock, 50 MHz, only clock
//  rst          in   1      synchronous, active-high reset
//  enable       in   1      0 forces IDLE; outputs hold reset values
//  canRx        in   1      raw bus input, asynchronous; 1 = recessive
//  brp          in   BRP_W  clocks per tq; 0 treated as 1
//  tseg1        in   SEG_W  TSEG1 length in tq, legal 2..15
//  tseg2        in   SEG_W  TSEG2 length in tq, legal 1..8
//  sjw          in   SEG_W  resync jump width in tq, legal 1..4, <= tseg2
//  sampleStrobe out  1      1-clock pulse; rxBit is valid in the same cycle
//  rxBit        out  1      last sampled bit
//  bitStart     out  1      1-clock pulse on entry to SYNC (transmit drive point)
//  synced       out  1      1 from hard sync until bus idle or disable
// BEHAVIOUR
//  Reset: sampleStrobe=0, bitStart=0, synced=0, rxBit=1, state=IDLE, all counters 0.
//  Input: two-flop synchroniser gives rxSync. rxPrev is rxSync delayed one clock.
//   edge = rxPrev & ~rxSync (recessive-to-dominant transitions only).
//  Prescaler: tqTick when preCnt==brp-1, then preCnt wraps to 0. preCnt is cleared on every (re)sync jump.
//  Config: brp/tseg1/tseg2/sjw are latched on every SYNC entry. Mid-bit changes take effect next bit.
//  States:
//   IDLE:  on edge & enable -> SYNC next clock; synced<=1 (hard sync).
//   SYNC:  1 tq, then TSEG1. Edges in SYNC are ignored.
//   TSEG1: tseg1+ext tq. ext = min(q+1, sjw), where q = tq index within TSEG1 at the edge.
//          On the final tqTick: sampleStrobe=1 and rxBit<=rxSync next clock, then go to TSEG2.
//   TSEG2: r = tseg2-q tq remain. On edge with r<=sjw: go to SYNC next clock (bit ends early).
//          Otherwise TSEG2 is shortened by sjw tq.
//  Resync allowed at most once per bit, and only if the previous rxBit was recessive.
//  Edge and tqTick in the same clock: the edge is evaluated with the pre-tick q.
//  Bus idle: IDLE_N consecutive recessive samples -> state IDLE, synced=0. enable=0 has the same effect next clock.
//  rst mid-bit: immediate return to reset values. No partial strobes.
//  Bit time = (1+tseg1+tseg2)*brp clocks.
//  Hard-sync latency: edge is detected 2 clocks after canRx is first sampled low.
//   First sampleStrobe occurs (1+tseg1)*brp+1 clocks after edge detection.
// STRUCTURE
//  can_timing_defs.vh: state localparams, RECESSIVE/DOMINANT constants, IDLE_N default.
//  Sub-module can_rx_sync: 2-flop synchroniser, rxPrev register, edge output.
//  Prescaler, segment FSM and idle counter live in this module.
// TESTING
//  Config for all tests: brp=5, tseg1=6, tseg2=3, sjw=1 (50 clocks/bit, 1 Mbit/s).
//  1 rst; canRx=1 for 100 clocks -> synced=0, no strobes, rxBit=1.
//  2 Hard sync: canRx falls at clock k and stays 0.
//    -> bitStart at k+3, sampleStrobe at k+38 with rxBit=0, then strobes every 50 clocks.
//  3 Late edge: recessive bit, then edge 2 tq into TSEG1 -> that sampleStrobe is delayed 5 clocks. Period restores after.
//  4 Early edge: edge with 1 tq left in TSEG2 -> bitStart the next clock; sampleStrobe 36 clocks after the edge.
//  5 Drive 11 recessive bits -> synced falls. The next falling edge hard-syncs exactly as in test 2.
//  6 rst pulsed mid-TSEG1, and enable dropped mid-TSEG2 -> all outputs at reset values next clock, no strobe emitted.

Source files
------------

// File: rtl/can_bit_timing_rx_pkg.sv
// Shared types and constants for the CAN receive bit-timing block.
package can_bit_timing_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StTseg1,
    StTseg2
  } state_e;

  localparam logic Recessive = 1'b1;
  localparam logic Dominant = 1'b0;
  localparam int unsigned IdleNDefault = 11;

  function automatic int umin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/can_bit_timing_rx_sync.sv
// Two-flop synchroniser for the raw bus line plus recessive-to-dominant edge detect.
module can_bit_timing_rx_sync
  import can_bit_timing_rx_pkg::*;
(
  input  logic clk50Mhz,
  input  logic rst,
  input  logic canRx,
  output logic rx_sync,
  output logic rx_edge
);

  logic meta;
  logic rx_prev;

  always_ff @(posedge clk50Mhz) begin
    if (rst) begin
      meta    <= Recessive;
      rx_sync <= Recessive;
      rx_prev <= Recessive;
    end else begin
      meta    <= canRx;
      rx_sync <= meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_edge = rx_prev & ~rx_sync;

endmodule

// File: rtl/can_bit_timing_rx.sv
// CAN receive bit-timing recovery: tq prescaler, SYNC/TSEG1/TSEG2 sequencer with hard sync,
// SJW-limited resync and bus-idle detection.
module can_bit_timing_rx
  import can_bit_timing_rx_pkg::*;
#(
  parameter int unsigned BRP_W  = 8,
  parameter int unsigned SEG_W  = 4,
  parameter int unsigned IDLE_N = IdleNDefault
) (
  input  logic             clk50Mhz,
  input  logic             rst,
  input  logic             enable,
  input  logic             canRx,
  input  logic [BRP_W-1:0] brp,
  input  logic [SEG_W-1:0] tseg1,
  input  logic [SEG_W-1:0] tseg2,
  input  logic [SEG_W-1:0] sjw,
  output logic             sampleStrobe,
  output logic             rxBit,
  output logic             bitStart,
  output logic             synced
);

  // TSEG1 can be extended past 15 tq, so the tq index needs one extra bit.
  localparam int unsigned QW = SEG_W + 1;
  localparam int unsigned IW = $clog2(IDLE_N + 1);

  state_e           state;
  logic             rx_sync;
  logic             rx_edge;
  logic [BRP_W-1:0] pre_cnt;
  logic [BRP_W-1:0] brp_l;
  logic [SEG_W-1:0] tseg1_l;
  logic [SEG_W-1:0] tseg2_l;
  logic [SEG_W-1:0] sjw_l;
  logic [SEG_W-1:0] ext;
  logic [SEG_W-1:0] shrink;
  logic [SEG_W-1:0] ext_new;
  logic [SEG_W-1:0] shrink_new;
  logic [QW-1:0]    q;
  logic [IW-1:0]    idle_cnt;
  logic             resynced;
  logic             tq_tick;
  logic             can_resync;
  logic             early;
  logic             seg1_end;
  logic             seg2_end;
  logic             go_sync;
  logic             bus_idle;

  can_bit_timing_rx_sync u_sync (
    .clk50Mhz (clk50Mhz),
    .rst      (rst),
    .canRx    (canRx),
    .rx_sync  (rx_sync),
    .rx_edge  (rx_edge)
  );

  always_comb begin
    tq_tick    = (pre_cnt == brp_l - BRP_W'(1));
    can_resync = rx_edge && !resynced && (rxBit == Recessive);
    ext_new    = ext;
    shrink_new = shrink;
    early      = 1'b0;
    // Edge evaluation uses the current (pre-tick) q even when a tick lands in the same clock.
    if (state == StTseg1 && can_resync) begin
      ext_new = SEG_W'(umin(int'(q) + 1, int'(sjw_l)));
    end else if (state == StTseg2 && can_resync) begin
      if (QW'(tseg2_l) - q <= QW'(sjw_l)) begin
        early = 1'b1;
      end else begin
        shrink_new = sjw_l;
      end
    end
    seg1_end = (state == StTseg1) && tq_tick &&
               (q == QW'(tseg1_l) + QW'(ext_new) - QW'(1));
    seg2_end = (state == StTseg2) && tq_tick &&
               (q == QW'(tseg2_l) - QW'(shrink_new) - QW'(1));
    go_sync  = ((state == StIdle) && rx_edge) || early || seg2_end;
    bus_idle = seg1_end && (rx_sync == Recessive) && (idle_cnt == IW'(IDLE_N - 1));
  end

  always_ff @(posedge clk50Mhz) begin
    if (rst || !enable) begin
      state        <= StIdle;
      pre_cnt      <= '0;
      q            <= '0;
      ext          <= '0;
      shrink       <= '0;
      resynced     <= 1'b0;
      idle_cnt     <= '0;
      brp_l        <= '0;
      tseg1_l      <= '0;
      tseg2_l      <= '0;
      sjw_l        <= '0;
      sampleStrobe <= 1'b0;
      bitStart     <= 1'b0;
      synced       <= 1'b0;
      rxBit        <= Recessive;
    end else begin
      sampleStrobe <= 1'b0;
      bitStart     <= 1'b0;
      pre_cnt      <= tq_tick ? '0 : pre_cnt + BRP_W'(1);
      if (can_resync && (state == StTseg1 || state == StTseg2)) begin
        resynced <= 1'b1;
        ext      <= ext_new;
        shrink   <= shrink_new;
        pre_cnt  <= '0;
      end
      unique case (state)
        StIdle: pre_cnt <= '0;
        StSync: begin
          if (tq_tick) begin
            state <= StTseg1;
            q     <= '0;
          end
        end
        StTseg1: begin
          if (seg1_end) begin
            sampleStrobe <= 1'b1;
            rxBit        <= rx_sync;
            state        <= StTseg2;
            q            <= '0;
            idle_cnt     <= (rx_sync == Recessive) ? idle_cnt + IW'(1) : '0;
          end else if (tq_tick) begin
            q <= q + QW'(1);
          end
        end
        StTseg2: begin
          if (tq_tick) begin
            q <= q + QW'(1);
          end
        end
        default: ;
      endcase
      // Configuration is only captured at bit boundaries so mid-bit writes never tear a bit.
      if (go_sync) begin
        state    <= StSync;
        bitStart <= 1'b1;
        synced   <= 1'b1;
        pre_cnt  <= '0;
        q        <= '0;
        ext      <= '0;
        shrink   <= '0;
        resynced <= 1'b0;
        brp_l    <= (brp == '0) ? BRP_W'(1) : brp;
        tseg1_l  <= tseg1;
        tseg2_l  <= tseg2;
        sjw_l    <= sjw;
      end
      if (bus_idle) begin
        state    <= StIdle;
        synced   <= 1'b0;
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_can_bit_timing_rx.sv
// Directed bench for can_bit_timing_rx: brp=5, tseg1=6, tseg2=3, sjw=1 (50 clocks per bit).
module tb_can_bit_timing_rx;

  logic       clk50Mhz = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       canRx = 1'b1;
  logic [7:0] brp = 8'd5;
  logic [3:0] tseg1 = 4'd6;
  logic [3:0] tseg2 = 4'd3;
  logic [3:0] sjw = 4'd1;
  logic       sampleStrobe;
  logic       rxBit;
  logic       bitStart;
  logic       synced;

  int cyc = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int n_strobe = 0;
  int n_bitstart = 0;
  int k, s0, s, t, t2, sb, base_s, base_b;

  can_bit_timing_rx dut (
    .clk50Mhz     (clk50Mhz),
    .rst          (rst),
    .enable       (enable),
    .canRx        (canRx),
    .brp          (brp),
    .tseg1        (tseg1),
    .tseg2        (tseg2),
    .sjw          (sjw),
    .sampleStrobe (sampleStrobe),
    .rxBit        (rxBit),
    .bitStart     (bitStart),
    .synced       (synced)
  );

  always #10 clk50Mhz = ~clk50Mhz;

  // cyc == n during the clock period that follows posedge n.
  always @(posedge clk50Mhz) cyc <= cyc + 1;

  always @(negedge clk50Mhz) begin
    if (sampleStrobe === 1'b1) n_strobe <= n_strobe + 1;
    if (bitStart === 1'b1) n_bitstart <= n_bitstart + 1;
  end

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk50Mhz);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    // Test 1: reset values, then a quiet recessive bus.
    wait_to(2);
    check("rst_strobe", sampleStrobe, 0);
    check("rst_bitstart", bitStart, 0);
    check("rst_synced", synced, 0);
    check("rst_rxbit", rxBit, 1);
    rst = 1'b0;
    wait_to(103);
    check("idle_synced", synced, 0);
    check("idle_rxbit", rxBit, 1);
    check("idle_nstrobe", n_strobe, 0);
    check("idle_nbitstart", n_bitstart, 0);

    // Test 2: hard sync, canRx changes in cycle k.
    k = 110;
    wait_to(k);
    canRx = 1'b0;
    s0 = k + 3;
    wait_to(s0 - 1);
    check("hs_bitstart_early", bitStart, 0);
    wait_to(s0);
    check("hs_bitstart", bitStart, 1);
    check("hs_synced", synced, 1);
    wait_to(s0 + 34);
    check("hs_strobe_early", sampleStrobe, 0);
    wait_to(s0 + 35);
    check("hs_strobe", sampleStrobe, 1);
    check("hs_rxbit", rxBit, 0);
    wait_to(s0 + 50);
    check("hs_bitstart2", bitStart, 1);
    wait_to(s0 + 85);
    check("hs_strobe2", sampleStrobe, 1);
    wait_to(s0 + 100);
    canRx = 1'b1;
    wait_to(s0 + 135);
    check("rec_strobe", sampleStrobe, 1);
    check("rec_rxbit", rxBit, 1);

    // Test 3: late edge on the tick ending TSEG1 tq 1 -> TSEG1 grows by sjw=1 tq.
    s = s0 + 150;
    wait_to(s + 12);
    canRx = 1'b0;
    wait_to(s + 35);
    check("late_nominal_strobe", sampleStrobe, 0);
    wait_to(s + 40);
    check("late_strobe", sampleStrobe, 1);
    check("late_rxbit", rxBit, 0);
    wait_to(s + 55);
    check("late_next_bitstart", bitStart, 1);
    wait_to(s + 90);
    check("late_period_restored", sampleStrobe, 1);

    // Test 4: recessive bit, then edge in the last TSEG2 tq -> bit ends early.
    t = s + 105;
    wait_to(t);
    canRx = 1'b1;
    wait_to(t + 35);
    check("early_prev_rxbit", rxBit, 1);
    wait_to(t + 44);
    canRx = 1'b0;
    wait_to(t + 46);
    check("early_bitstart_pre", bitStart, 0);
    wait_to(t + 47);
    check("early_bitstart", bitStart, 1);
    wait_to(t + 82);
    check("early_strobe", sampleStrobe, 1);
    check("early_rxbit", rxBit, 0);

    // Test 5: eleven recessive samples drop synced; the next fall hard-syncs again.
    t2 = t + 97;
    wait_to(t2);
    canRx = 1'b1;
    wait_to(t2 + 485);
    check("idle10_strobe", sampleStrobe, 1);
    check("idle10_synced", synced, 1);
    wait_to(t2 + 535);
    check("idle11_strobe", sampleStrobe, 1);
    check("idle11_rxbit", rxBit, 1);
    check("idle11_synced", synced, 0);
    wait_to(t2 + 550);
    check("idle_no_bitstart", bitStart, 0);
    k = t2 + 600;
    wait_to(k);
    canRx = 1'b0;
    wait_to(k + 2);
    check("rehs_bitstart_early", bitStart, 0);
    wait_to(k + 3);
    check("rehs_bitstart", bitStart, 1);
    check("rehs_synced", synced, 1);
    wait_to(k + 37);
    check("rehs_strobe_early", sampleStrobe, 0);
    wait_to(k + 38);
    check("rehs_strobe", sampleStrobe, 1);
    check("rehs_rxbit", rxBit, 0);

    // Test 6a: rst in the middle of TSEG1 of the second bit.
    s = k + 3;
    wait_to(s + 69);
    check("pre_rst_rxbit", rxBit, 0);
    rst = 1'b1;
    canRx = 1'b1;
    wait_to(s + 70);
    rst = 1'b0;
    check("midrst_strobe", sampleStrobe, 0);
    check("midrst_bitstart", bitStart, 0);
    check("midrst_synced", synced, 0);
    check("midrst_rxbit", rxBit, 1);
    base_s = n_strobe;
    base_b = n_bitstart;
    wait_to(s + 170);
    check("midrst_no_strobes", n_strobe, base_s);
    check("midrst_no_bitstarts", n_bitstart, base_b);

    // Test 6b: enable dropped in the middle of TSEG2.
    k = s + 200;
    wait_to(k);
    canRx = 1'b0;
    sb = k + 3;
    wait_to(sb + 35);
    check("en_strobe", sampleStrobe, 1);
    check("en_rxbit", rxBit, 0);
    wait_to(sb + 41);
    check("en_synced_pre", synced, 1);
    enable = 1'b0;
    wait_to(sb + 42);
    check("dis_synced", synced, 0);
    check("dis_rxbit", rxBit, 1);
    check("dis_strobe", sampleStrobe, 0);
    check("dis_bitstart", bitStart, 0);
    base_s = n_strobe;
    base_b = n_bitstart;
    wait_to(sb + 150);
    check("dis_no_strobes", n_strobe, base_s);
    check("dis_no_bitstarts", n_bitstart, base_b);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
